// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory. Port 0 has
// fixed priority; port 1 is promoted once it has been denied MAX_WAIT cycles.
module mem_arbiter #(
  parameter int unsigned AW       = 9,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  logic          starve;
  logic          any_gnt;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  assign starve = (wait_cnt_q == CW'(MAX_WAIT));

  // Arbitration and memory command; grants are masked while in reset.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    win_we    = we0;
    win_addr  = addr0;
    win_wdata = wdata0;
    if (rst) begin
      if (req1 && (!req0 || starve)) begin
        gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end
    end
    if (gnt1) begin
      win_we    = we1;
      win_addr  = addr1;
      win_wdata = wdata1;
    end
    any_gnt   = gnt0 | gnt1;
    mem_rd    = any_gnt & ~win_we;
    mem_wr    = any_gnt & win_we;
    mem_addr  = any_gnt ? win_addr  : mem_addr_q;
    mem_wdata = any_gnt ? win_wdata : mem_wdata_q;
  end

  // Next-state: last-grant FSM, read owner pipeline and port 1 starvation count.
  always_comb begin
    state_d    = IDLE;
    owner_d    = OWN_NONE;
    wait_cnt_d = '0;
    if (gnt0) begin
      state_d = OWN0;
    end else if (gnt1) begin
      state_d = OWN1;
    end
    if (mem_rd) begin
      owner_d = gnt1 ? OWN_P1 : OWN_P0;
    end
    if (req1 && !gnt1) begin
      wait_cnt_d = (wait_cnt_q < CW'(MAX_WAIT)) ? wait_cnt_q + CW'(1) : wait_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      wait_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // A pending read return must belong to the port granted last cycle.
      if (owner_q == OWN_P0) assert (state_q == OWN0);
      if (owner_q == OWN_P1) assert (state_q == OWN1);
      state_q     <= state_d;
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
    end
  end

  assign rvalid0 = (owner_q == OWN_P0);
  assign rvalid1 = (owner_q == OWN_P1);
  assign rdata   = (rvalid0 | rvalid1) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous memory model
// (write lands at the edge, read data appears one cycle after mem_rd).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [8:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_rd, mem_wr;
  logic [31:0] rdata, mem_wdata;
  logic [8:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem [512];

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.AW(9), .DW(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    req0 = 1'b1; req1 = 1'b1; addr0 = 9'h055; wdata0 = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      #2;
      checks++; if ({gnt0, gnt1, rvalid0, rvalid1, mem_rd, mem_wr} !== 6'b0) begin
        failures++; $display("FAIL reset_ctrl got=%b exp=000000", {gnt0, gnt1, rvalid0, rvalid1, mem_rd, mem_wr});
      end
      checks++; if (mem_addr !== 9'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin
        failures++; $display("FAIL reset_data got addr=%h wdata=%h rdata=%h exp=0", mem_addr, mem_wdata, rdata);
      end
      checks++; if (dut.wait_cnt_q !== 4'd0) begin
        failures++; $display("FAIL reset_wait_cnt got=%0d exp=0", dut.wait_cnt_q);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    req0 = 1'b1; addr0 = 9'h010;
    #1;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 9'h010) begin
      failures++; $display("FAIL s1_grant got gnt0=%b gnt1=%b rd=%b addr=%h exp 1 0 1 010", gnt0, gnt1, mem_rd, mem_addr);
    end
    @(negedge clk);
    req0 = 1'b0;
    #1;
    checks++; if (rvalid0 !== 1'b1 || rdata !== 32'h1234_5678) begin
      failures++; $display("FAIL s1_return got rvalid0=%b rdata=%h exp 1 12345678", rvalid0, rdata);
    end
    checks++; if (rvalid1 !== 1'b0 || gnt0 !== 1'b0) begin
      failures++; $display("FAIL s1_quiet got rvalid1=%b gnt0=%b exp 0 0", rvalid1, gnt0);
    end
    @(negedge clk);
    #1;
    checks++; if (rvalid0 !== 1'b0) begin
      failures++; $display("FAIL s1_single_pulse got rvalid0=%b exp=0", rvalid0);
    end
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req0 = 1'b1; addr0 = 9'h001; req1 = 1'b1; addr1 = 9'h002;
      #1;
      checks++; if (gnt1 !== ((i % 5) == 4) || gnt0 !== ((i % 5) != 4)) begin
        failures++; $display("FAIL s2_pattern cyc=%0d got gnt0=%b gnt1=%b exp gnt1=%b", i, gnt0, gnt1, (i % 5) == 4);
      end
      if ((i % 5) == 4) begin
        checks++; if (dut.wait_cnt_q !== 4'd4) begin
          failures++; $display("FAIL s2_wait_cnt cyc=%0d got=%0d exp=4", i, dut.wait_cnt_q);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_raw();
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 9'h1FF; wdata1 = 32'hDEAD_BEEF;
    #1;
    checks++; if (gnt1 !== 1'b1 || mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 9'h1FF || mem_wdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL s3_write got gnt1=%b wr=%b rd=%b addr=%h wdata=%h", gnt1, mem_wr, mem_rd, mem_addr, mem_wdata);
    end
    @(negedge clk);
    idle_inputs();
    req0 = 1'b1; addr0 = 9'h1FF;
    #1;
    checks++; if (gnt0 !== 1'b1 || mem_rd !== 1'b1 || mem_wr !== 1'b0 || rvalid1 !== 1'b0) begin
      failures++; $display("FAIL s3_read got gnt0=%b rd=%b wr=%b rvalid1=%b exp 1 1 0 0", gnt0, mem_rd, mem_wr, rvalid1);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rvalid0 !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL s3_return got rvalid0=%b rdata=%h exp 1 deadbeef", rvalid0, rdata);
    end
    checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 9'h1FF) begin
      failures++; $display("FAIL s3_hold got rd=%b wr=%b addr=%h exp 0 0 1ff", mem_rd, mem_wr, mem_addr);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req0 = (i < 8); addr0 = 9'(i);
      #1;
      checks++; if (gnt0 !== (i < 8)) begin
        failures++; $display("FAIL s4_gnt0 cyc=%0d got=%b exp=%b", i, gnt0, i < 8);
      end
      if (i >= 1 && i <= 8) begin
        checks++; if (rvalid0 !== 1'b1 || rdata !== 32'hA000_0000 + 32'(i - 1)) begin
          failures++; $display("FAIL s4_return cyc=%0d got rvalid0=%b rdata=%h exp 1 %h", i, rvalid0, rdata, 32'hA000_0000 + 32'(i - 1));
        end
      end else begin
        checks++; if (rvalid0 !== 1'b0) begin
          failures++; $display("FAIL s4_no_return cyc=%0d got rvalid0=%b exp=0", i, rvalid0);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req1 = 1'b1; addr1 = 9'h005;
    #1;
    checks++; if (gnt1 !== 1'b1 || mem_rd !== 1'b1) begin
      failures++; $display("FAIL s5_grant got gnt1=%b rd=%b exp 1 1", gnt1, mem_rd);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (gnt1 !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 9'h0) begin
      failures++; $display("FAIL s5_async got gnt1=%b rd=%b addr=%h exp 0 0 000", gnt1, mem_rd, mem_addr);
    end
    @(negedge clk);
    #1;
    checks++; if ({gnt0, gnt1, rvalid0, rvalid1, mem_rd, mem_wr} !== 6'b0 || rdata !== 32'h0 || mem_wdata !== 32'h0) begin
      failures++; $display("FAIL s5_in_reset got ctrl=%b rdata=%h wdata=%h exp 0", {gnt0, gnt1, rvalid0, rvalid1, mem_rd, mem_wr}, rdata, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    req0 = 1'b1; addr0 = 9'h003;
    #1;
    checks++; if (gnt0 !== 1'b1 || rvalid1 !== 1'b0) begin
      failures++; $display("FAIL s5_release got gnt0=%b rvalid1=%b exp 1 0", gnt0, rvalid1);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 32'hA000_0003) begin
      failures++; $display("FAIL s5_return got rvalid0=%b rvalid1=%b rdata=%h exp 1 0 a0000003", rvalid0, rvalid1, rdata);
    end
  endtask

  task automatic test_wait_clear();
    logic [3:0] exp_cnt [6] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd1};
    logic       req1_v  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req0 = req1_v[i]; req1 = req1_v[i]; addr1 = 9'h020;
      #1;
      checks++; if (dut.wait_cnt_q !== exp_cnt[i] || gnt1 !== 1'b0) begin
        failures++; $display("FAIL s6_wait_cnt cyc=%0d got cnt=%0d gnt1=%b exp cnt=%0d gnt1=0", i, dut.wait_cnt_q, gnt1, exp_cnt[i]);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 512; a++) mem[a] <= 32'hA000_0000 + 32'(a);
    mem[16] <= 32'h1234_5678;
    test_reset();
    test_single_read();
    test_starvation();
    test_raw();
    test_back_to_back();
    test_reset_mid();
    test_wait_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
